// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - frame geometry constants and pixel address type for the video path
package video_pkg;
  localparam int H_PIXELS = 320;
  localparam int V_LINES  = 240;
  localparam int FRAME_PX = H_PIXELS * V_LINES;
  localparam int ADDR_W   = 17;

  typedef logic [ADDR_W-1:0] pix_addr_t;
endpackage

// File: rtl/dp_bram_1b.sv
// rtl/dp_bram_1b.sv - 1-bit simple dual-port RAM, one write port and one registered read port
module dp_bram_1b #(
  parameter int DEPTH = 2 * video_pkg::FRAME_PX,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  logic          write_data,
  input  logic          read_en,
  input  logic [AW-1:0] read_addr,
  output logic          read_data
);
  // No reset on the array or read register so the tools can map this onto block RAM.
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (read_en) read_data <= mem[read_addr];
  end
endmodule

// File: rtl/interlaced_frame_buffer.sv
// rtl/interlaced_frame_buffer.sv - ping-pong 1bpp frame store: sequential fill bank, random-read display bank
module interlaced_frame_buffer
  import video_pkg::*;
#(
  parameter int LINE_WIDTH  = H_PIXELS,
  parameter int FRAME_LINES = V_LINES
) (
  input  logic      clk,
  input  logic      reset,
  input  pix_addr_t read_addr,
  input  logic      reading,
  input  logic      pixel_in,
  output logic      pixel_out
);
  localparam int        FRAME     = LINE_WIDTH * FRAME_LINES;
  localparam int        PHYS_W    = $clog2(2 * FRAME);
  localparam pix_addr_t LAST_ADDR = pix_addr_t'(FRAME - 1);
  localparam logic [PHYS_W-1:0] BANK_OFFSET = PHYS_W'(FRAME);

  pix_addr_t         wr_addr;
  logic              wr_bank;
  logic              frame_valid;
  logic              rd_gate;
  logic              rd_en;
  logic              ram_q;
  logic [PHYS_W-1:0] wr_phys;
  logic [PHYS_W-1:0] rd_phys;

  // Reader always targets the bank not being filled, so no read/write collision exists.
  assign rd_en   = reading && frame_valid && (read_addr <= LAST_ADDR);
  assign wr_phys = (wr_bank ? BANK_OFFSET : '0) + PHYS_W'(wr_addr);
  assign rd_phys = (wr_bank ? '0 : BANK_OFFSET) + PHYS_W'(read_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr     <= '0;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b0;
      rd_gate     <= 1'b0;
    end else begin
      wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + pix_addr_t'(1);
      if (wr_addr == LAST_ADDR) begin
        wr_bank     <= ~wr_bank;
        frame_valid <= 1'b1;
      end
      rd_gate <= rd_en;
    end
  end

  dp_bram_1b #(
    .DEPTH(2 * FRAME),
    .AW   (PHYS_W)
  ) u_ram (
    .clk       (clk),
    .write_en  (!reset),
    .write_addr(wr_phys),
    .write_data(pixel_in),
    .read_en   (rd_en),
    .read_addr (rd_phys),
    .read_data (ram_q)
  );

  // Gate is registered alongside the RAM read so a masked read yields 0 with the same latency.
  assign pixel_out = ram_q & rd_gate;
endmodule

// File: tb/tb_interlaced_frame_buffer.sv
// tb/tb_interlaced_frame_buffer.sv - directed checks of banking, swap timing, read gating and mid-frame reset
module tb_interlaced_frame_buffer;
  import video_pkg::*;

  localparam int W = 32;
  localparam int H = 8;
  localparam int F = W * H;

  logic      clk = 1'b0;
  logic      reset;
  pix_addr_t read_addr;
  logic      reading;
  logic      pixel_in;
  logic      pixel_out;

  int tests = 0;
  int fails = 0;

  interlaced_frame_buffer #(.LINE_WIDTH(W), .FRAME_LINES(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .read_addr(read_addr),
    .reading  (reading),
    .pixel_in (pixel_in),
    .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    int addrs [7];
    logic exps [7];
    addrs = '{0, 1, 2, 3, 99, 254, 255};
    exps  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; reading = 1'b0; read_addr = '0; pixel_in = 1'b0;
    repeat (10) tick();
    check("reset_out", pixel_out, 1'b0);
    reading = 1'b1; read_addr = pix_addr_t'(50);
    tick();
    check("reset_read", pixel_out, 1'b0);

    // Frame 0: first half 0, second half 1; nothing readable yet.
    reset = 1'b0;
    for (int k = 0; k < F; k++) begin
      pixel_in = (k >= F / 2);
      reading = 1'b1;
      read_addr = pix_addr_t'(k % 101);
      tick();
      check("f0_no_frame", pixel_out, 1'b0);
    end

    // Frame 1: all ones into the other bank while frame 0 is displayed.
    for (int k = 0; k < F; k++) begin
      logic exp;
      pixel_in = 1'b1;
      reading = 1'b1;
      exp = 1'b0;
      case (k)
        0: read_addr = pix_addr_t'(100);
        1: begin read_addr = pix_addr_t'(200); exp = 1'b1; end
        2: begin reading = 1'b0; read_addr = pix_addr_t'(200); end
        3: read_addr = pix_addr_t'(F);
        4: read_addr = pix_addr_t'(76800);
        5: read_addr = pix_addr_t'(131071);
        default: read_addr = (k >= F - 4) ? pix_addr_t'(5) : pix_addr_t'(k % (F / 2));
      endcase
      tick();
      case (k)
        0: check("f1_read100", pixel_out, exp);
        1: check("f1_read200", pixel_out, exp);
        2: check("f1_reading0", pixel_out, exp);
        3: check("f1_addr_frame", pixel_out, exp);
        4: check("f1_addr76800", pixel_out, exp);
        5: check("f1_addr_max", pixel_out, exp);
        default: check((k >= F - 4) ? "swap_before" : "bank_isolation", pixel_out, exp);
      endcase
    end

    // Frame 2 (odd pattern) until mid-frame reset; display shows frame 1 (all ones).
    for (int k = 0; k < 100; k++) begin
      pixel_in = k[0];
      reading = 1'b1;
      read_addr = (k == 0) ? pix_addr_t'(5) : ((k == 1) ? pix_addr_t'(0) : pix_addr_t'(k * 2));
      tick();
      check((k == 0) ? "swap_after" : ((k == 1) ? "f1_addr0" : "f1_readback"), pixel_out, 1'b1);
    end

    reset = 1'b1; read_addr = pix_addr_t'(10);
    tick();
    check("midreset_out", pixel_out, 1'b0);
    tick();
    check("midreset_hold", pixel_out, 1'b0);
    reset = 1'b0;

    // Frame 3 after reset: pixel = (idx % 3 == 0); masked until complete.
    for (int k = 0; k < F; k++) begin
      pixel_in = (k % 3 == 0);
      reading = 1'b1;
      read_addr = pix_addr_t'((k * 7) % F);
      tick();
      check("f3_masked", pixel_out, 1'b0);
    end

    pixel_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      reading = 1'b1;
      read_addr = pix_addr_t'(addrs[i]);
      tick();
      check($sformatf("f3_data_%0d", addrs[i]), pixel_out, exps[i]);
    end
    reading = 1'b0; read_addr = pix_addr_t'(0);
    tick();
    check("f3_reading0", pixel_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
